// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- single-issue instruction fetch stage
//
// Holds the program counter, reads one word per cycle from a combinational
// instruction memory and hands it to decode through a registered
// valid/ready packet. A downstream redirect reloads the PC and flushes the
// packet in flight, which costs one bubble.
//
// State machine:
//   BOOT : one idle cycle after reset, no fetch
//   RUN  : normal fetching
//   HALT : no fetch; a packet already presented still drains to decode.
//          Left only through a redirect.
//
// Optional feature (macro FETCH_ZERO_HALT_EN):
//   When defined, a fetched all-zero word is treated as the illegal/stop
//   encoding. It is not presented, the PC does not advance, and the FSM
//   enters HALT. When undefined, zero words are ordinary instructions,
//   HALT is never entered and halted is tied to 0.
//
// Ports:
//   clk            in   clock, all state changes on its rising edge
//   reset          in   synchronous, active-high reset
//   imem_addr      out  [10:0] word address to instruction memory (pc[12:2])
//   imem_data      in   [31:0] instruction word for imem_addr (combinational)
//   redirect_valid in   branch/jump target request from downstream
//   redirect_pc    in   [31:0] redirect target byte address (low bits ignored)
//   id_ready       in   decode accepts the presented packet this cycle
//   if_valid       out  fetch packet valid
//   if_pc          out  [31:0] byte address of the presented instruction
//   if_instr       out  [31:0] presented instruction word
//   halted         out  high while the FSM is in HALT
//
// Parameter:
//   RESET_PC       byte address loaded into the PC on reset
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        halted
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc;
  logic        fire;
  logic        zero_word;
  logic        hit_zero;

  // Redirect targets are word aligned; the two low bits are dropped on load.
  logic        unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // The memory is word addressed; pc[12:2] wraps 2047 -> 0 on its own.
  assign imem_addr = pc[12:2];

  // A fetch may only overwrite the output register when it is empty or being
  // consumed this cycle; a redirect always suppresses it.
  assign fire = (state == ST_RUN) && !redirect_valid && (!if_valid || id_ready);

`ifdef FETCH_ZERO_HALT_EN
  assign zero_word = (imem_data == 32'h0000_0000);
  assign halted    = (state == ST_HALT);
`else
  assign zero_word = 1'b0;
  assign halted    = 1'b0;
`endif

  assign hit_zero = fire && zero_word;

  // NOTE: state_next gets a default before the case so that no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      // BOOT always completes, even if a redirect arrives during it; the
      // redirect's PC load is handled in the datapath below.
      ST_BOOT: state_next = ST_RUN;
      ST_RUN:  if (hit_zero) state_next = ST_HALT;
      ST_HALT: if (redirect_valid) state_next = ST_RUN;
      default: state_next = ST_BOOT;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset wins over any redirect or pending packet in the same cycle.
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= 32'h0000_0000;
      if_instr <= 32'h0000_0000;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        // Flush: the packet in flight is dropped and fetching restarts at the
        // target on the following cycle (one bubble).
        pc       <= {redirect_pc[31:2], 2'b00};
        if_valid <= 1'b0;
      end else if (fire) begin
        if (hit_zero) begin
          // The illegal word is swallowed; the previous packet (if any) is
          // being consumed this cycle, so the output simply empties.
          if_valid <= 1'b0;
        end else begin
          if_valid <= 1'b1;
          if_pc    <= pc;
          if_instr <= imem_data;
          pc       <= pc + 32'd4;
        end
      end else if (if_valid && id_ready) begin
        if_valid <= 1'b0;
      end
      // Otherwise if_valid && !id_ready: everything holds (backpressure).
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit
//
// A cycle table drives reset/redirect/id_ready and checks the presented
// packet and imem_addr after each edge. Packets that decode is expected to
// accept are pushed to a scoreboard queue when the row is driven; a monitor
// pops and compares them whenever a handshake is seen. Hand-written
// sequences cover redirect during BOOT and the all-zero word behaviour
// (either build of FETCH_ZERO_HALT_EN).
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:2047];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } pkt_t;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        push;       // packet shown after this row will be consumed
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [10:0] exp_addr;
  } vec_t;

  pkt_t sb[$];
  vec_t vq[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[a[12:2]];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
  endtask

  task automatic push_pkt(input logic [31:0] a);
    pkt_t p;
    p.pc    = a;
    p.instr = word_at(a);
    sb.push_back(p);
  endtask

  task automatic add(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic push, input logic v, input logic [31:0] pc, input logic [10:0] addr);
    vec_t x;
    x.rst = rst; x.rv = rv; x.rpc = rpc; x.rdy = rdy; x.push = push;
    x.exp_valid = v; x.exp_pc = pc; x.exp_addr = addr;
    vq.push_back(x);
  endtask

  // Handshake monitor: sampled on the falling edge, i.e. the values decode
  // sees for the next rising edge. Flushed or reset cycles are not transfers.
  always @(negedge clk) begin
    if (reset === 1'b0 && redirect_valid === 1'b0 && if_valid === 1'b1 && id_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got packet pc %h, expected no transfer", if_pc);
      end else begin
        pkt_t p;
        p = sb.pop_front();
        check("sb_pc", if_pc, p.pc);
        check("sb_instr", if_instr, p.instr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h0000_2303;
    mem[1] = 32'h0000_2383;
    mem[2] = 32'h0400_2023;
    drive(1'b1, 1'b0, 32'h0, 1'b1);

    //  rst rv  rpc           rdy push v  pc            addr
    // Reset, BOOT bubble, then 0,4,8 back to back.
    add(1, 0, 32'h0,        1, 0, 0, 32'h0,        11'd0);
    add(0, 0, 32'h0,        1, 0, 0, 32'h0,        11'd0);
    add(0, 0, 32'h0,        1, 1, 1, 32'h0,        11'd1);
    add(0, 0, 32'h0,        1, 1, 1, 32'h4,        11'd2);
    add(0, 0, 32'h0,        1, 0, 1, 32'h8,        11'd3);
    // Backpressure for three cycles while pc 4 is presented.
    add(1, 0, 32'h0,        1, 0, 0, 32'h0,        11'd0);
    add(0, 0, 32'h0,        1, 0, 0, 32'h0,        11'd0);
    add(0, 0, 32'h0,        1, 1, 1, 32'h0,        11'd1);
    add(0, 0, 32'h0,        1, 1, 1, 32'h4,        11'd2);
    add(0, 0, 32'h0,        0, 0, 1, 32'h4,        11'd2);
    add(0, 0, 32'h0,        0, 0, 1, 32'h4,        11'd2);
    add(0, 0, 32'h0,        0, 0, 1, 32'h4,        11'd2);
    add(0, 0, 32'h0,        1, 1, 1, 32'h8,        11'd3);
    add(0, 0, 32'h0,        1, 1, 1, 32'hC,        11'd4);
    add(0, 0, 32'h0,        1, 0, 1, 32'h10,       11'd5);
    // Redirect to an unaligned target: one bubble, then 0x50.
    add(0, 1, 32'h51,       1, 0, 0, 32'h0,        11'd20);
    add(0, 0, 32'h0,        1, 1, 1, 32'h50,       11'd21);
    add(0, 0, 32'h0,        1, 0, 1, 32'h54,       11'd22);
    // Address wrap past the top of the 2K-word memory.
    add(0, 1, 32'h1FFC,     1, 0, 0, 32'h0,        11'd2047);
    add(0, 0, 32'h0,        1, 1, 1, 32'h1FFC,     11'd0);
    add(0, 0, 32'h0,        1, 1, 1, 32'h2000,     11'd1);
    add(0, 0, 32'h0,        1, 0, 1, 32'h2004,     11'd2);
    add(0, 0, 32'h0,        0, 0, 1, 32'h2004,     11'd2);
    // Reset while a packet is stalled; then a fire with id_ready low.
    add(1, 0, 32'h0,        0, 0, 0, 32'h0,        11'd0);
    add(0, 0, 32'h0,        0, 0, 0, 32'h0,        11'd0);
    add(0, 0, 32'h0,        0, 1, 1, 32'h0,        11'd1);
    add(0, 0, 32'h0,        0, 0, 1, 32'h0,        11'd1);
    add(0, 0, 32'h0,        1, 0, 1, 32'h4,        11'd2);

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].rst, vq[k].rv, vq[k].rpc, vq[k].rdy);
      if (vq[k].push) push_pkt(vq[k].exp_pc);
      step();
      check($sformatf("row%0d_valid", k), {31'b0, if_valid}, {31'b0, vq[k].exp_valid});
      check($sformatf("row%0d_addr", k), {21'b0, imem_addr}, {21'b0, vq[k].exp_addr});
      check($sformatf("row%0d_halted", k), {31'b0, halted}, 32'h0);
      if (vq[k].rst) begin
        check($sformatf("row%0d_rst_pc", k), if_pc, 32'h0);
        check($sformatf("row%0d_rst_instr", k), if_instr, 32'h0);
      end else if (vq[k].exp_valid) begin
        check($sformatf("row%0d_pc", k), if_pc, vq[k].exp_pc);
        check($sformatf("row%0d_instr", k), if_instr, word_at(vq[k].exp_pc));
      end
    end

    // Redirect arriving during BOOT: BOOT still takes its cycle, fetch starts
    // at the target right after.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step();
    drive(1'b0, 1'b1, 32'h102, 1'b1);
    step();
    check("boot_redir_valid", {31'b0, if_valid}, 32'h0);
    check("boot_redir_addr", {21'b0, imem_addr}, 32'h40);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    push_pkt(32'h100);
    step();
    check("boot_redir_pc", if_pc, 32'h100);
    check("boot_redir_v", {31'b0, if_valid}, 32'h1);
    step();
    check("boot_redir_next", if_pc, 32'h104);

    // All-zero word at address 12.
    mem[3] = 32'h0000_0000;
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    step();
    push_pkt(32'h0);
    step();
    push_pkt(32'h4);
    step();
    push_pkt(32'h8);
    step();
    check("zero_pre_pc", if_pc, 32'h8);
`ifdef FETCH_ZERO_HALT_EN
    step();
    check("zero_halted", {31'b0, halted}, 32'h1);
    check("zero_valid", {31'b0, if_valid}, 32'h0);
    check("zero_last_pc", if_pc, 32'h8);
    check("zero_addr_hold", {21'b0, imem_addr}, 32'h3);
    step();
    check("zero_halt_stays", {31'b0, halted}, 32'h1);
    check("zero_halt_nofetch", {31'b0, if_valid}, 32'h0);
`else
    push_pkt(32'hC);
    step();
    check("zero_plain_valid", {31'b0, if_valid}, 32'h1);
    check("zero_plain_pc", if_pc, 32'hC);
    check("zero_plain_instr", if_instr, 32'h0);
    check("zero_plain_halted", {31'b0, halted}, 32'h0);
    step();
    check("zero_plain_next", if_pc, 32'h10);
    check("zero_plain_halted2", {31'b0, halted}, 32'h0);
`endif
    drive(1'b0, 1'b1, 32'h0, 1'b1);
    step();
    check("resume_halted", {31'b0, halted}, 32'h0);
    check("resume_bubble", {31'b0, if_valid}, 32'h0);
    check("resume_addr", {21'b0, imem_addr}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    push_pkt(32'h0);
    step();
    check("resume_pc", if_pc, 32'h0);
    check("resume_instr", if_instr, 32'h0000_2303);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check("sb_empty", sb.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
